// File: rtl/core_run_pkg.sv
// Shared types and constants for the core run controller.
package core_run_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } run_state_e;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_HALT    = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
  localparam logic [1:0] CAUSE_STUCK   = 2'd3;

  localparam int unsigned RD_W          = 5;
  localparam int unsigned CNT_W         = 32;
  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam int unsigned TRACE_ENTRY_W = 2 * XLEN_DEFAULT + RD_W;

  // Trace entry is {pc, rd, data}
  function automatic int unsigned trace_entry_w(input int unsigned xlen);
    return 2 * xlen + RD_W;
  endfunction

  // Saturating increment for the run counters
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/core_run_ctrl_trace_fifo.sv
// Writeback trace FIFO: combinational head, same-cycle push/pop, drop when full.
module trace_fifo
  import core_run_pkg::*;
#(
  parameter int unsigned WIDTH = TRACE_ENTRY_W,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push_c;
  logic             do_pop_c;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign pop_data = mem[rd_ptr];

  // A pop frees a slot for a same-cycle push even when full
  always_comb begin
    do_pop_c  = pop && !empty;
    do_push_c = push && (!full || do_pop_c);
  end

  // Storage write; pointers define validity so no reset is needed here
  always_ff @(posedge clk) begin
    if (do_push_c) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and level bookkeeping; pointers wrap modulo DEPTH
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push_c, do_pop_c})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/core_run_ctrl.sv
// Run controller and commit monitor for the single-cycle RISC-V core.
module core_run_ctrl
  import core_run_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     RESET_HOLD  = 2,
  parameter int unsigned     MAX_CYCLES  = 20,
  parameter int unsigned     STUCK_LIMIT = 4,
  parameter logic [XLEN-1:0] HALT_INSTR  = XLEN'(32'h00000073),
  parameter int unsigned     TRACE_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [XLEN-1:0]                pc_in,
  input  logic [XLEN-1:0]                instr_in,
  input  logic                           rd_we_in,
  input  logic [4:0]                     rd_addr_in,
  input  logic [XLEN-1:0]                rd_data_in,
  input  logic                           trace_rd_en,
  output logic                           core_reset,
  output logic                           running,
  output logic                           done,
  output logic [1:0]                     done_cause,
  output logic [31:0]                    cycle_count,
  output logic [31:0]                    retired_count,
  output logic                           trace_valid,
  output logic [XLEN-1:0]                trace_pc,
  output logic [4:0]                     trace_rd,
  output logic [XLEN-1:0]                trace_data,
  output logic [$clog2(TRACE_DEPTH):0]   trace_level,
  output logic                           trace_overflow
);

  localparam int unsigned ENTRY_W = trace_entry_w(XLEN);
  localparam int unsigned HOLD_W  = $clog2(RESET_HOLD + 1);
  localparam int unsigned STUCK_W = $clog2(STUCK_LIMIT + 1);

  run_state_e          state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [XLEN-1:0]     prev_pc;
  logic                prev_valid;
  logic [STUCK_W-1:0]  eq_cnt;

  logic                clear_c;
  logic                push_c;
  logic                pop_c;
  logic                halt_c;
  logic                eq_now_c;
  logic                stuck_c;
  logic                timeout_c;

  logic [ENTRY_W-1:0]  push_entry;
  logic [ENTRY_W-1:0]  head_entry;
  logic                fifo_full;
  logic                fifo_empty;

  // Run-state decode: start edge, trace push/pop and termination conditions
  always_comb begin
    clear_c   = start && ((state == IDLE) || (state == DONE));
    push_c    = (state == RUN) && rd_we_in && (rd_addr_in != 5'd0);
    pop_c     = trace_rd_en && !fifo_empty;
    halt_c    = (instr_in == HALT_INSTR);
    eq_now_c  = prev_valid && (pc_in == prev_pc);
    stuck_c   = eq_now_c && (eq_cnt == STUCK_W'(STUCK_LIMIT - 2));
    timeout_c = (cycle_count == 32'(MAX_CYCLES - 1));
  end

  // FSM with registered outputs, counters and stuck-PC detector
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      core_reset    <= 1'b1;
      running       <= 1'b0;
      done          <= 1'b0;
      done_cause    <= CAUSE_NONE;
      cycle_count   <= '0;
      retired_count <= '0;
      hold_cnt      <= '0;
      prev_pc       <= '0;
      prev_valid    <= 1'b0;
      eq_cnt        <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= HOLD;
            core_reset    <= 1'b1;
            running       <= 1'b0;
            done          <= 1'b0;
            done_cause    <= CAUSE_NONE;
            cycle_count   <= '0;
            retired_count <= '0;
            hold_cnt      <= '0;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_W'(RESET_HOLD - 1)) begin
            state      <= RUN;
            core_reset <= 1'b0;
            running    <= 1'b1;
            prev_valid <= 1'b0;
            eq_cnt     <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        RUN: begin
          cycle_count <= sat_inc(cycle_count);
          if (push_c) retired_count <= sat_inc(retired_count);
          prev_pc    <= pc_in;
          prev_valid <= 1'b1;
          eq_cnt     <= eq_now_c ? eq_cnt + STUCK_W'(1) : '0;
          if (halt_c || stuck_c || timeout_c) begin
            state      <= DONE;
            core_reset <= 1'b1;
            running    <= 1'b0;
            done       <= 1'b1;
            if (halt_c)       done_cause <= CAUSE_HALT;
            else if (stuck_c) done_cause <= CAUSE_STUCK;
            else              done_cause <= CAUSE_TIMEOUT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky overflow: a push lost because the FIFO was full and not popped
  always_ff @(posedge clk) begin
    if (!reset || clear_c) begin
      trace_overflow <= 1'b0;
    end else if (push_c && fifo_full && !pop_c) begin
      trace_overflow <= 1'b1;
    end
  end

  assign push_entry = {pc_in, rd_addr_in, rd_data_in};

  trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear_c),
    .push      (push_c),
    .push_data (push_entry),
    .pop       (trace_rd_en),
    .pop_data  (head_entry),
    .level     (trace_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign trace_valid = !fifo_empty;
  assign trace_pc    = head_entry[ENTRY_W-1 -: XLEN];
  assign trace_rd    = head_entry[XLEN +: 5];
  assign trace_data  = head_entry[XLEN-1:0];

endmodule

// File: tb/tb_core_run_ctrl.sv
// Self-checking bench for core_run_ctrl with a trace scoreboard.
module tb_core_run_ctrl;

  localparam logic [31:0] ECALL = 32'h00000073;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] ADDI  = 32'h00500093;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] pc_in;
  logic [31:0] instr_in;
  logic        rd_we_in;
  logic [4:0]  rd_addr_in;
  logic [31:0] rd_data_in;
  logic        trace_rd_en;
  logic        core_reset;
  logic        running;
  logic        done;
  logic [1:0]  done_cause;
  logic [31:0] cycle_count;
  logic [31:0] retired_count;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [4:0]  trace_rd;
  logic [31:0] trace_data;
  logic [3:0]  trace_level;
  logic        trace_overflow;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t sb[$];
  bit   exp_ovf;
  int   exp_retired;
  int   tests;
  int   failed;

  core_run_ctrl #(
    .XLEN        (32),
    .RESET_HOLD  (2),
    .MAX_CYCLES  (20),
    .STUCK_LIMIT (4),
    .HALT_INSTR  (32'h00000073),
    .TRACE_DEPTH (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .pc_in          (pc_in),
    .instr_in       (instr_in),
    .rd_we_in       (rd_we_in),
    .rd_addr_in     (rd_addr_in),
    .rd_data_in     (rd_data_in),
    .trace_rd_en    (trace_rd_en),
    .core_reset     (core_reset),
    .running        (running),
    .done           (done),
    .done_cause     (done_cause),
    .cycle_count    (cycle_count),
    .retired_count  (retired_count),
    .trace_valid    (trace_valid),
    .trace_pc       (trace_pc),
    .trace_rd       (trace_rd),
    .trace_data     (trace_data),
    .trace_level    (trace_level),
    .trace_overflow (trace_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "bench watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a run from IDLE/DONE and advance to the first RUN cycle
  task automatic go_run();
    sb.delete();
    exp_ovf     = 1'b0;
    exp_retired = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    tests++; if (running !== 1'b1) begin failed++; $display("FAIL go_run_running got=%0b exp=1", running); end
  endtask

  // One RUN cycle; scoreboard models trace pushes, drops and pops
  task automatic run_cycle(input logic [31:0] pc, input logic [31:0] instr, input logic we,
                           input logic [4:0] rd, input logic [31:0] data, input logic pop);
    ent_t e;
    pc_in = pc; instr_in = instr; rd_we_in = we; rd_addr_in = rd; rd_data_in = data;
    trace_rd_en = pop;
    if (pop && sb.size() > 0) begin
      e = sb.pop_front();
      tests++; if (trace_valid !== 1'b1 || trace_pc !== e.pc || trace_rd !== e.rd || trace_data !== e.data) begin
        failed++; $display("FAIL run_pop_head got=%0b/%h/%0d/%h exp=1/%h/%0d/%h", trace_valid, trace_pc, trace_rd, trace_data, e.pc, e.rd, e.data);
      end
    end
    if (we && rd != 5'd0) begin
      exp_retired++;
      if (sb.size() < 8) begin
        e.pc = pc; e.rd = rd; e.data = data;
        sb.push_back(e);
      end else begin
        exp_ovf = 1'b1;
      end
    end
    step();
    rd_we_in = 1'b0; trace_rd_en = 1'b0;
  endtask

  // Pop one entry outside RUN and compare against the scoreboard
  task automatic pop_check();
    ent_t e;
    if (sb.size() == 0) begin
      failed++; tests++; $display("FAIL pop_check_empty got=empty_model exp=entry");
    end else begin
      e = sb.pop_front();
      tests++; if (trace_valid !== 1'b1 || trace_pc !== e.pc || trace_rd !== e.rd || trace_data !== e.data) begin
        failed++; $display("FAIL drain_head got=%0b/%h/%0d/%h exp=1/%h/%0d/%h", trace_valid, trace_pc, trace_rd, trace_data, e.pc, e.rd, e.data);
      end
    end
    trace_rd_en = 1'b1;
    step();
    trace_rd_en = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    tests++; if (core_reset !== 1'b1 || running !== 1'b0 || done !== 1'b0 || done_cause !== 2'd0) begin
      failed++; $display("FAIL %s_ctrl got=%0b%0b%0b/%0d exp=100/0", tag, core_reset, running, done, done_cause);
    end
    tests++; if (cycle_count !== 32'd0 || retired_count !== 32'd0) begin
      failed++; $display("FAIL %s_counts got=%0d/%0d exp=0/0", tag, cycle_count, retired_count);
    end
    tests++; if (trace_valid !== 1'b0 || trace_level !== 4'd0 || trace_overflow !== 1'b0) begin
      failed++; $display("FAIL %s_fifo got=%0b/%0d/%0b exp=0/0/0", tag, trace_valid, trace_level, trace_overflow);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; trace_rd_en = 1'b0;
    pc_in = '0; instr_in = NOP; rd_we_in = 1'b0; rd_addr_in = '0; rd_data_in = '0;
    step();
    step();
    check_reset_vals("reset");
    reset = 1'b1;
    step();
    tests++; if (core_reset !== 1'b1) begin failed++; $display("FAIL idle_core_reset got=%0b exp=1", core_reset); end
  endtask

  task automatic test_start_seq();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tests++; if (core_reset !== 1'b1 || running !== 1'b0) begin
        failed++; $display("FAIL hold_%0d got=%0b%0b exp=10", i, core_reset, running);
      end
      step();
    end
    tests++; if (core_reset !== 1'b0 || running !== 1'b1 || cycle_count !== 32'd0) begin
      failed++; $display("FAIL run_entry got=%0b%0b/%0d exp=01/0", core_reset, running, cycle_count);
    end
    for (int i = 1; i <= 2; i++) begin
      run_cycle(32'(i * 4), NOP, 1'b0, 5'd0, 32'd0, 1'b0);
      tests++; if (cycle_count !== 32'(i)) begin failed++; $display("FAIL run_count got=%0d exp=%0d", cycle_count, i); end
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_halt();
    go_run();
    run_cycle(32'h0, ADDI, 1'b1, 5'd1, 32'd5, 1'b0);
    run_cycle(32'h4, NOP, 1'b0, 5'd0, 32'd0, 1'b0);
    run_cycle(32'h8, ECALL, 1'b0, 5'd0, 32'd0, 1'b0);
    tests++; if (done !== 1'b1 || done_cause !== 2'd1 || running !== 1'b0 || core_reset !== 1'b1) begin
      failed++; $display("FAIL halt_state got=%0b/%0d/%0b%0b exp=1/1/01", done, done_cause, running, core_reset);
    end
    tests++; if (cycle_count !== 32'd3 || retired_count !== 32'(exp_retired)) begin
      failed++; $display("FAIL halt_counts got=%0d/%0d exp=3/%0d", cycle_count, retired_count, exp_retired);
    end
    pop_check();
    tests++; if (trace_valid !== 1'b0) begin failed++; $display("FAIL halt_drained got=%0b exp=0", trace_valid); end
  endtask

  task automatic test_stuck();
    go_run();
    for (int i = 0; i < 3; i++) run_cycle(32'h10, NOP, 1'b0, 5'd0, 32'd0, 1'b0);
    tests++; if (done !== 1'b0) begin failed++; $display("FAIL stuck_early got=%0b exp=0", done); end
    run_cycle(32'h10, NOP, 1'b0, 5'd0, 32'd0, 1'b0);
    tests++; if (done !== 1'b1 || done_cause !== 2'd3 || cycle_count !== 32'd4) begin
      failed++; $display("FAIL stuck_end got=%0b/%0d/%0d exp=1/3/4", done, done_cause, cycle_count);
    end
  endtask

  task automatic test_timeout();
    go_run();
    for (int i = 0; i < 20; i++) begin
      run_cycle(32'(i * 4), NOP, 1'b0, 5'd0, 32'd0, 1'b0);
      if (i == 18) begin
        tests++; if (done !== 1'b0 || cycle_count !== 32'd19) begin
          failed++; $display("FAIL timeout_early got=%0b/%0d exp=0/19", done, cycle_count);
        end
      end
    end
    tests++; if (done !== 1'b1 || done_cause !== 2'd2 || cycle_count !== 32'd20) begin
      failed++; $display("FAIL timeout_end got=%0b/%0d/%0d exp=1/2/20", done, done_cause, cycle_count);
    end
  endtask

  task automatic test_overflow();
    // Fill, then push+pop while full must not overflow
    go_run();
    for (int i = 0; i < 8; i++) run_cycle(32'(i * 4), NOP, 1'b1, 5'd5, 32'(100 + i), 1'b0);
    tests++; if (trace_level !== 4'd8 || trace_overflow !== 1'b0) begin
      failed++; $display("FAIL full_level got=%0d/%0b exp=8/0", trace_level, trace_overflow);
    end
    run_cycle(32'h20, NOP, 1'b1, 5'd5, 32'd108, 1'b1);
    tests++; if (trace_level !== 4'd8 || trace_overflow !== exp_ovf) begin
      failed++; $display("FAIL full_pushpop got=%0d/%0b exp=8/%0b", trace_level, trace_overflow, exp_ovf);
    end
    run_cycle(32'h24, ECALL, 1'b0, 5'd0, 32'd0, 1'b0);
    // Restart clears the FIFO, then overflow with 10 pushes
    go_run();
    tests++; if (trace_level !== 4'd0 || trace_valid !== 1'b0 || trace_overflow !== 1'b0) begin
      failed++; $display("FAIL restart_clear got=%0d/%0b/%0b exp=0/0/0", trace_level, trace_valid, trace_overflow);
    end
    for (int i = 0; i < 10; i++) run_cycle(32'h100 + 32'(i * 4), NOP, 1'b1, 5'd5, 32'(200 + i), 1'b0);
    tests++; if (trace_level !== 4'd8 || trace_overflow !== exp_ovf || retired_count !== 32'(exp_retired)) begin
      failed++; $display("FAIL ovf_state got=%0d/%0b/%0d exp=8/%0b/%0d", trace_level, trace_overflow, retired_count, exp_ovf, exp_retired);
    end
    run_cycle(32'h200, ECALL, 1'b0, 5'd0, 32'd0, 1'b0);
    for (int i = 0; i < 8; i++) pop_check();
    tests++; if (trace_valid !== 1'b0 || trace_level !== 4'd0) begin
      failed++; $display("FAIL drain_empty got=%0b/%0d exp=0/0", trace_valid, trace_level);
    end
    trace_rd_en = 1'b1;
    step();
    trace_rd_en = 1'b0;
    tests++; if (trace_level !== 4'd0 || trace_overflow !== 1'b1 || done !== 1'b1) begin
      failed++; $display("FAIL empty_pop got=%0d/%0b/%0b exp=0/1/1", trace_level, trace_overflow, done);
    end
  endtask

  task automatic test_x0_and_reset();
    go_run();
    run_cycle(32'h0, NOP, 1'b1, 5'd0, 32'hdead, 1'b0);
    tests++; if (retired_count !== 32'(exp_retired) || trace_level !== 4'(sb.size())) begin
      failed++; $display("FAIL x0_first got=%0d/%0d exp=%0d/%0d", retired_count, trace_level, exp_retired, sb.size());
    end
    run_cycle(32'h4, NOP, 1'b1, 5'd3, 32'h33, 1'b0);
    run_cycle(32'h8, NOP, 1'b1, 5'd0, 32'h77, 1'b0);
    tests++; if (retired_count !== 32'(exp_retired) || trace_level !== 4'(sb.size())) begin
      failed++; $display("FAIL x0_mixed got=%0d/%0d exp=%0d/%0d", retired_count, trace_level, exp_retired, sb.size());
    end
    reset = 1'b0;
    step();
    check_reset_vals("midrun");
    reset = 1'b1;
    step();
  endtask

  initial begin
    tests = 0; failed = 0; exp_ovf = 1'b0; exp_retired = 0;
    test_reset();
    test_start_seq();
    test_halt();
    test_stuck();
    test_timeout();
    test_overflow();
    test_x0_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
- Synthesizable run controller and commit monitor for the single-cycle RISC-V core.
- Generates the core reset pulse and counts cycles and retirements.
- Ends a run on a halt instruction, a stuck PC or a cycle timeout, and buffers register-writeback events in a trace FIFO.
- Replaces fixed-delay bench sequencing with a parametrised, self-terminating harness that can be used on FPGA or in simulation.

Parameters:
- XLEN, 32, width of PC, instruction and writeback data.
- RESET_HOLD, 2, number of cycles core_reset is held high (≥1).
- MAX_CYCLES, 20, RUN-state cycle budget before timeout (≥1).
- STUCK_LIMIT, 4, consecutive cycles with an unchanged PC that count as stuck (≥2).
- HALT_INSTR, 32'h00000073, instruction encoding that ends the run (ecall).
- TRACE_DEPTH, 8, trace FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse that begins a run (honoured in IDLE or DONE).
- pc_in  in  XLEN  current core PC.
- instr_in  in  XLEN  current core instruction.
- rd_we_in  in  1  core register-file write enable.
- rd_addr_in  in  5  core destination register.
- rd_data_in  in  XLEN  core writeback data.
- trace_rd_en  in  1  pop request for the trace FIFO.
- core_reset  out  1  active-high reset to the core.
- running  out  1  high in the RUN state.
- done  out  1  high in the DONE state.
- done_cause  out  2  0=none, 1=halt, 2=timeout, 3=stuck.
- cycle_count  out  32  number of RUN cycles elapsed.
- retired_count  out  32  number of RUN cycles with rd_we_in=1 and rd_addr_in≠0.
- trace_valid  out  1  FIFO not empty.
- trace_pc  out  XLEN  head-entry PC.
- trace_rd  out  5  head-entry register.
- trace_data  out  XLEN  head-entry data.
- trace_level  out  $clog2(TRACE_DEPTH)+1  number of entries held.
- trace_overflow  out  1  sticky flag: a push was dropped.

Behaviour:
- Reset (reset=0 at a clk edge):
  - State goes to IDLE.
  - core_reset=1, running=0, done=0, done_cause=0.
  - All counters are 0.
  - FIFO is emptied and trace_overflow=0.
  - Reset mid-run aborts the run immediately; there is no drain.
- IDLE:
  - core_reset=1.
  - start → HOLD. On that edge, clear the counters, done_cause, the FIFO and trace_overflow.
- HOLD:
  - core_reset=1 for exactly RESET_HOLD cycles, then → RUN.
  - start is ignored.
- RUN:
  - core_reset=0 and running=1.
  - cycle_count increments every cycle.
  - Termination is checked every cycle, in priority order halt > stuck > timeout:
    - halt: instr_in==HALT_INSTR.
    - stuck: pc_in has equalled the previous cycle's pc_in for STUCK_LIMIT-1 consecutive cycles, i.e. STUCK_LIMIT equal samples. The first RUN cycle has no previous sample.
    - timeout: cycle_count==MAX_CYCLES-1 in this cycle.
  - When a condition is met → DONE on the next edge, and done_cause latches the winning condition.
  - The terminating cycle is still counted and its writeback is still traced.
- DONE:
  - core_reset=1, done=1.
  - Counters and done_cause hold.
  - The FIFO remains readable.
  - start → HOLD, which re-clears everything as on the IDLE→HOLD edge.
- Trace push:
  - A push happens in RUN when rd_we_in=1 and rd_addr_in≠0. The entry is {pc_in, rd_addr_in, rd_data_in}.
  - Writes to x0 are neither traced nor counted as retired.
- FIFO rules:
  - The head is presented combinationally; trace_rd_en while trace_valid=1 pops it at the edge.
  - trace_rd_en while empty is ignored.
  - Push when full with no pop: the entry is dropped, trace_overflow goes to 1 (sticky), and the level stays at TRACE_DEPTH.
  - Push and pop in the same cycle when full: both happen, the level is unchanged, no overflow.
  - Push and pop in the same cycle when empty: only the push happens.
  - Read and write pointers wrap modulo TRACE_DEPTH.
- Counters saturate at 32'hFFFFFFFF.

Decomposition:
- Shared package core_run_pkg:
  - state enum: IDLE, HOLD, RUN, DONE.
  - done_cause constants: CAUSE_NONE, CAUSE_HALT, CAUSE_TIMEOUT, CAUSE_STUCK.
  - trace entry width constant.
- One sub-module, trace_fifo (parametrised WIDTH and DEPTH), which provides push, pop, level, full and empty.
- The FSM, counters and stuck detector live in core_run_ctrl.

Test Plan:
1. Reset and start sequence: hold reset=0 for 2 cycles, release, pulse start. Required: core_reset=1 through IDLE plus exactly 2 HOLD cycles, then running=1 with cycle_count counting 0,1,2,…
2. Halt: the core executes addi x1,x0,5 then ecall (0x00000073) at the 3rd RUN cycle. Required: done=1 the next cycle, done_cause=1, cycle_count=3, retired_count=1, and the trace head is {pc, rd=1, data=5}.
3. Stuck: pc_in is held at 0x10 from RUN cycle 0 onward. Required: done_cause=3 after 4 equal samples, with cycle_count=4.
4. Timeout: the PC increments by 4 each cycle with no halt and MAX_CYCLES=20. Required: done_cause=2 and cycle_count=20.
5. FIFO overflow: 10 writebacks to x5 with no pops and TRACE_DEPTH=8. Required: trace_level=8, trace_overflow=1, and popping returns the first 8 entries in order. Also: push and pop together when full leaves the level at 8 with no further overflow.
6. x0 filter and mid-run reset: writebacks to x0 leave retired_count and trace_level unchanged. Asserting reset=0 during RUN returns to IDLE with all outputs at their reset values on the next edge.
